// File: rtl/mips_mem_arbiter.sv
// Two-requester arbiter/sequencer that shares one fixed-latency, single-ported memory
// between the MIPS fetch port and data port. Data has priority, with a bounded fetch-starvation guard.
module mips_mem_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int LATENCY     = 2,
  parameter int MAX_DSTREAK = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          gnt_d
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam logic [2:0] WAIT_LOAD  = 3'(LATENCY - 1);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

  state_e        state_q, state_d;
  logic [2:0]    wait_q, wait_d;
  logic [3:0]    streak_q, streak_d;
  logic          own_d_q, own_d_d;
  logic          is_wr_q, is_wr_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          i_ready_q, i_ready_d;
  logic          d_ready_q, d_ready_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          d_wins;

  // Data loses only when fetch is waiting and has already watched MAX_DSTREAK data grants.
  assign d_wins = d_req && !(i_req && (streak_q == STREAK_MAX));

  // NOTE: every _d gets its hold value first, so no path through this block leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    streak_d    = streak_q;
    own_d_d     = own_d_q;
    is_wr_d     = is_wr_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          own_d_d  = d_wins;
          mem_en_d = 1'b1;
          state_d  = ISSUE;
          if (d_wins) begin
            is_wr_d     = d_we;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            if (i_req) begin
              streak_d = (streak_q == 4'hF) ? streak_q : streak_q + 4'd1;
            end else begin
              streak_d = '0;
            end
          end else begin
            is_wr_d    = 1'b0;
            mem_we_d   = 1'b0;
            mem_addr_d = i_addr;
            streak_d   = '0;
          end
        end
      end

      ISSUE: begin
        mem_we_d = 1'b0;
        wait_d   = WAIT_LOAD;
        state_d  = WAIT;
      end

      WAIT: begin
        if (wait_q == '0) begin
          if (own_d_q) begin
            d_ready_d = 1'b1;
            if (!is_wr_q) begin
              d_rdata_d = mem_rdata;
            end
          end else begin
            i_ready_d = 1'b1;
            i_rdata_d = mem_rdata;
          end
          state_d = RESP;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end

      RESP: begin
        // The finishing requester still holds req here, so no arbitration this cycle.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every register
  // samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      streak_q    <= '0;
      own_d_q     <= 1'b0;
      is_wr_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      streak_q    <= streak_d;
      own_d_q     <= own_d_d;
      is_wr_q     <= is_wr_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign gnt_d     = own_d_q;

  a_strobe_single: assert property (@(posedge clk) disable iff (!reset) mem_en_q |=> !mem_en_q);
  a_ready_excl:    assert property (@(posedge clk) disable iff (!reset) !(i_ready_q && d_ready_q));

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Randomized scoreboard bench for mips_mem_arbiter: requester drivers, a memory model,
// and a transaction-level reference that predicts grants, strobe timing and responses.
module tb_mips_mem_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int MAXS = 4;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  typedef struct {
    bit            is_d;
    logic [DW-1:0] rdata;
    int            due;
  } resp_t;

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
  } rd_t;

  logic          clk;
  logic          reset;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          i_ready, d_ready, mem_en, mem_we, gnt_d;

  logic          l1_i_req;
  logic [DW-1:0] l1_i_rdata, l1_d_rdata, l1_mem_wdata, l1_mem_rdata;
  logic [AW-1:0] l1_mem_addr;
  logic          l1_i_ready, l1_d_ready, l1_mem_en, l1_mem_we, l1_gnt_d;

  int cyc = 0;
  int vec = 0;
  int errs = 0;

  txn_t  i_stim[$], d_stim[$];
  txn_t  i_q[$], d_q[$];
  resp_t rq[$];
  rd_t   rdq[$];
  bit    glog[$];
  logic [DW-1:0] mem_arr [logic [AW-1:0]];
  logic [DW-1:0] mem_ref [logic [AW-1:0]];

  bit            i_on = 0, d_on = 0;
  int            i_gap = 0, d_gap = 0;
  int            streak = 0;
  int            exp_en = -1;
  int            free_cyc = 0;
  bit            snap_i, snap_d;
  bit            in_rst = 1;
  logic [DW-1:0] d_last = '0;

  mips_mem_arbiter #(.AW(AW), .DW(DW), .LATENCY(LAT), .MAX_DSTREAK(MAXS)) u_dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .gnt_d(gnt_d)
  );

  mips_mem_arbiter #(.AW(AW), .DW(DW), .LATENCY(1), .MAX_DSTREAK(MAXS)) u_dut_l1 (
    .clk(clk), .reset(reset),
    .i_req(l1_i_req), .i_addr(32'h0000_0200), .i_rdata(l1_i_rdata), .i_ready(l1_i_ready),
    .d_req(1'b0), .d_we(1'b0), .d_addr('0), .d_wdata('0),
    .d_rdata(l1_d_rdata), .d_ready(l1_d_ready),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_rdata(l1_mem_rdata), .gnt_d(l1_gnt_d)
  );

  // The LATENCY=1 memory returns a word stamped with the current cycle number.
  assign l1_mem_rdata = {8'hA5, cyc[23:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return mem_ref.exists(a) ? mem_ref[a] : init_word(a);
  endfunction

  function automatic txn_t rand_txn(input bit is_d);
    txn_t t;
    t.we    = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
    t.addr  = 32'h100 + 32'($urandom_range(0, 7)) * 4;
    t.wdata = $urandom;
    return t;
  endfunction

  // Single-ported memory with a fixed read latency.
  initial begin : memory
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_rdata = $urandom;
      while (rdq.size() > 0 && rdq[0].due <= cyc) begin
        rd_t r;
        r = rdq.pop_front();
        if (r.due == cyc) mem_rdata = mem_arr.exists(r.addr) ? mem_arr[r.addr] : init_word(r.addr);
      end
      if (reset === 1'b1 && mem_en) begin
        if (mem_we) mem_arr[mem_addr] = mem_wdata;
        else rdq.push_back('{due: cyc + LAT, addr: mem_addr});
      end
    end
  end

  task automatic await_ready(input bit is_d);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(is_d ? d_ready : i_ready) && n < 64);
    if (n >= 64) begin
      if (is_d) check("d_ready_timeout", d_ready, 1);
      else check("i_ready_timeout", i_ready, 1);
    end
  endtask

  task automatic drive_fetch();
    txn_t t;
    forever begin
      @(posedge clk); #1;
      if (i_stim.size() > 0 || (i_on && $urandom_range(0, i_gap) == 0)) begin
        t = (i_stim.size() > 0) ? i_stim.pop_front() : rand_txn(1'b0);
        i_q.push_back(t);
        i_addr = t.addr;
        i_req  = 1'b1;
        await_ready(1'b0);
      end else begin
        i_req = 1'b0;
      end
    end
  endtask

  task automatic drive_data();
    txn_t t;
    forever begin
      @(posedge clk); #1;
      if (d_stim.size() > 0 || (d_on && $urandom_range(0, d_gap) == 0)) begin
        t = (d_stim.size() > 0) ? d_stim.pop_front() : rand_txn(1'b1);
        d_q.push_back(t);
        d_we    = t.we;
        d_addr  = t.addr;
        d_wdata = t.wdata;
        d_req   = 1'b1;
        await_ready(1'b1);
      end else begin
        d_req = 1'b0;
      end
    end
  endtask

  // Reference: predicts the winner from the pending requests and the streak rule,
  // then queues the expected completion LAT+1 cycles after the strobe.
  task automatic do_grant();
    bit    win_d;
    txn_t  t;
    resp_t r;
    win_d = snap_d && !(snap_i && streak == MAXS);
    check("gnt_d", gnt_d, win_d);
    glog.push_back(gnt_d);
    if ((win_d ? d_q.size() : i_q.size()) == 0) begin
      check("grant_without_request", 1'b0, 1'b1);
      return;
    end
    t = win_d ? d_q[0] : i_q[0];
    check("mem_we", mem_we, win_d & t.we);
    check("mem_addr", mem_addr, t.addr);
    if (win_d && t.we) begin
      check("mem_wdata", mem_wdata, t.wdata);
      mem_ref[t.addr] = t.wdata;
      r.rdata = d_last;
    end else begin
      r.rdata = ref_read(t.addr);
      if (win_d) d_last = r.rdata;
    end
    r.is_d = win_d;
    r.due  = cyc + LAT + 1;
    rq.push_back(r);
    if (win_d && snap_i) streak = (streak < 15) ? streak + 1 : 15;
    else streak = 0;
    free_cyc = cyc + LAT + 2;
  endtask

  initial begin : monitor
    bit    prev_en;
    resp_t r;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        rq.delete();
        exp_en  = -1;
        streak  = 0;
        d_last  = '0;
        in_rst  = 1;
        prev_en = 1'b0;
      end else begin
        if (in_rst) begin
          in_rst   = 0;
          free_cyc = cyc;
        end
        if (mem_en) begin
          check("mem_en_timing", cyc, exp_en);
          check("mem_en_back_to_back", prev_en, 0);
          if (exp_en == cyc) do_grant();
          exp_en = -1;
        end else if (exp_en == cyc) begin
          check("mem_en_missing", mem_en, 1);
          exp_en   = -1;
          free_cyc = cyc;
        end
        prev_en = mem_en;

        if (i_ready || d_ready) begin
          check("ready_exclusive", i_ready & d_ready, 0);
          if (rq.size() == 0) begin
            check("spurious_ready", {i_ready, d_ready}, 0);
          end else begin
            r = rq.pop_front();
            check("ready_cycle", cyc, r.due);
            check("ready_port", d_ready, r.is_d);
            if (r.is_d) begin
              check("d_rdata", d_rdata, r.rdata);
              if (d_q.size() > 0) void'(d_q.pop_front());
            end else begin
              check("i_rdata", i_rdata, r.rdata);
              if (i_q.size() > 0) void'(i_q.pop_front());
            end
          end
        end else if (rq.size() > 0 && cyc > rq[0].due) begin
          r = rq.pop_front();
          check("ready_missing", {i_ready, d_ready}, r.is_d ? 2 : 1);
        end

        if (exp_en < 0 && cyc >= free_cyc && (i_req || d_req)) begin
          exp_en = cyc + 1;
          snap_i = i_req;
          snap_d = d_req;
        end
      end
    end
  end

  task automatic expect_ready(input bit is_d, input int exp_cyc, input bit chk,
                              input logic [DW-1:0] exp_data, input string name);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 64) begin
      @(posedge clk); #3;
      n++;
      seen = is_d ? d_ready : i_ready;
    end
    check({name, "_seen"}, seen, 1);
    if (seen) begin
      check({name, "_cycle"}, cyc, exp_cyc);
      if (chk) check({name, "_data"}, is_d ? d_rdata : i_rdata, exp_data);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((i_req || d_req || i_q.size() != 0 || d_q.size() != 0 || rq.size() != 0) && n < 300) begin
      @(posedge clk); #3;
      n++;
    end
    check("drain_in_time", n < 300, 1);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int t0, n, seen, en_cnt, rdy_cnt;
    logic [DW-1:0] expw;
    reset = 1'b0;
    i_req = 0; d_req = 0; d_we = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    l1_i_req = 0;
    mem_arr[32'h80] = 32'h1000_FFFF;
    mem_ref[32'h80] = 32'h1000_FFFF;
    fork
      drive_fetch();
      drive_data();
    join_none

    repeat (3) @(posedge clk);
    #3;
    check("reset_ctrl", {mem_en, mem_we, i_ready, d_ready, gnt_d}, 0);
    check("reset_data", mem_addr | mem_wdata | i_rdata | d_rdata, 0);
    @(posedge clk); #2;
    reset = 1'b1;

    // LATENCY=1 instance: ready three cycles after the request is sampled.
    @(posedge clk); #3;
    l1_i_req = 1'b1;
    t0 = cyc;
    n = 0; seen = 0;
    while (!seen && n < 32) begin
      @(posedge clk); #3;
      n++;
      seen = l1_i_ready;
    end
    check("l1_ready_seen", seen, 1);
    check("l1_ready_cycle", cyc, t0 + 3);
    expw = {8'hA5, 24'(t0 + 2)};
    check("l1_rdata", l1_i_rdata, expw);
    @(posedge clk); #3;
    l1_i_req = 1'b0;
    check("l1_ready_one_cycle", l1_i_ready, 0);

    // Single fetch of a preloaded word.
    @(posedge clk); #3;
    i_stim.push_back('{we: 1'b0, addr: 32'h80, wdata: '0});
    t0 = cyc + 1;
    expect_ready(1'b0, t0 + LAT + 2, 1'b1, 32'h1000_FFFF, "single_fetch");
    wait_idle();

    // Data write: d_rdata stays at its reset value.
    @(posedge clk); #3;
    d_stim.push_back('{we: 1'b1, addr: 32'h80, wdata: 32'h0000_DEAD});
    t0 = cyc + 1;
    expect_ready(1'b1, t0 + LAT + 2, 1'b1, 32'h0, "data_write");
    wait_idle();

    // Simultaneous requests: data first, fetch strobed LAT+3 cycles later.
    @(posedge clk); #3;
    d_stim.push_back('{we: 1'b0, addr: 32'h40, wdata: '0});
    i_stim.push_back('{we: 1'b0, addr: 32'h80, wdata: '0});
    t0 = cyc + 1;
    fork
      expect_ready(1'b1, t0 + LAT + 2, 1'b0, '0, "simul_data");
      expect_ready(1'b0, t0 + 2 * LAT + 5, 1'b1, 32'h0000_DEAD, "simul_fetch");
    join
    wait_idle();

    // Both requesters held continuously: MAXS data grants, then one fetch, repeating.
    glog.delete();
    @(posedge clk); #3;
    i_gap = 0; d_gap = 0;
    i_on = 1; d_on = 1;
    n = 0;
    while (glog.size() < 11 && n < 200) begin
      @(posedge clk); #3;
      n++;
    end
    i_on = 0; d_on = 0;
    check("starve_grants_seen", glog.size() >= 11, 1);
    for (int k = 0; k < 11 && k < glog.size(); k++)
      check($sformatf("starve_grant_%0d", k), glog[k], (k % (MAXS + 1)) != MAXS);
    wait_idle();

    // Random traffic.
    i_gap = 2; d_gap = 1;
    i_on = 1; d_on = 1;
    repeat (500) @(posedge clk);
    i_on = 0; d_on = 0;
    wait_idle();

    // Idle: nothing may move for 100 cycles.
    en_cnt = 0; rdy_cnt = 0;
    repeat (100) begin
      @(posedge clk); #3;
      en_cnt  += int'(mem_en);
      rdy_cnt += int'(i_ready) + int'(d_ready);
    end
    check("idle_mem_en", en_cnt, 0);
    check("idle_ready", rdy_cnt, 0);

    // Reset during WAIT abandons the access; the held request is served afresh after release.
    @(posedge clk); #3;
    d_stim.push_back('{we: 1'b0, addr: 32'h104, wdata: '0});
    n = 0;
    while (!mem_en && n < 32) begin
      @(posedge clk); #3;
      n++;
    end
    check("rst_test_strobe", mem_en, 1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("rst_async_ctrl", {mem_en, mem_we, i_ready, d_ready, gnt_d}, 0);
    check("rst_async_data", mem_addr | mem_wdata | i_rdata | d_rdata, 0);
    rdy_cnt = 0;
    repeat (3) begin
      @(posedge clk); #3;
      rdy_cnt += int'(i_ready) + int'(d_ready);
    end
    check("rst_no_ready", rdy_cnt, 0);
    @(posedge clk); #2;
    reset = 1'b1;
    t0 = cyc;
    expect_ready(1'b1, t0 + LAT + 2, 1'b0, '0, "rst_reaccess");
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/mips_mem_arbiter.md
# mips_mem_arbiter

Two-requester arbiter and access sequencer that lets the pipelined MIPS instruction-fetch port and data-memory port share one single-ported, fixed-latency memory. It sits between the IF/MEM stages of `pipelined_mips` and a unified memory array. It serialises accesses, gives the data port (the older instruction) priority, and guarantees fetch forward progress with a bounded starvation guard. Each requester holds its request until a one-cycle ready pulse; the pipeline stalls on `!ready`.

## Interface
- `AW`, 32: address width (byte address, passed through unchanged).
- `DW`, 32: data width.
- `LATENCY`, 2: memory read latency in cycles after `mem_en`; legal range 1..7.
- `MAX_DSTREAK`, 4: consecutive data grants allowed while fetch is pending; legal range 1..15.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `i_req` in 1: fetch request, held until `i_ready`.
- `i_addr` in AW: fetch address, stable while `i_req`.
- `i_rdata` out DW: fetched word, valid in the `i_ready` cycle.
- `i_ready` out 1: one-cycle completion pulse for fetch.
- `d_req` in 1: data request, held until `d_ready`.
- `d_we` in 1: 1 = write, 0 = read; stable while `d_req`.
- `d_addr` in AW: data address.
- `d_wdata` in DW: write data.
- `d_rdata` out DW: load data, valid in the `d_ready` cycle.
- `d_ready` out 1: one-cycle completion pulse for data.
- `mem_en` out 1: memory access strobe, one cycle per access.
- `mem_we` out 1: write enable, qualified by `mem_en`.
- `mem_addr` out AW: memory address.
- `mem_wdata` out DW: memory write data.
- `mem_rdata` in DW: memory read data, valid exactly LATENCY cycles after the `mem_en` cycle.
- `gnt_d` out 1: owner of the current or last access (1 = data, 0 = fetch).

## Operation
- All outputs are registered.
- Reset values: `mem_en`, `mem_we`, `i_ready`, `d_ready`, `gnt_d` = 0; `mem_addr`, `mem_wdata`, `i_rdata`, `d_rdata` = 0; streak counter = 0; state = IDLE.
- **IDLE** (no request): stay in IDLE.
- **IDLE** (any request), winner selection:
  - Data wins if `d_req && !(i_req && streak == MAX_DSTREAK)`; otherwise fetch wins.
  - Latch the winner into `gnt_d`, register `mem_*` from the winner's inputs with `mem_en` = 1, and go to ISSUE.
  - Streak update on a grant: a data grant while `i_req` = 1 increments the counter (saturating). A fetch grant clears it. A data grant with `i_req` = 0 clears it.
- **ISSUE**: `mem_en` is high for this single cycle. Then deassert `mem_en` and `mem_we`, load the wait counter with LATENCY-1, and go to WAIT. `mem_addr` and `mem_wdata` hold their values.
- **WAIT**: decrement the counter. When the counter is 0:
  - Capture `mem_rdata` into the winner's rdata register. Writes leave `d_rdata` unchanged.
  - Set the winner's ready, and go to RESP.
- **RESP**: the ready pulse is high for this single cycle. Clear it and go to IDLE. Requests are not evaluated in RESP, because the completing requester's `req` is still high in that cycle.
- Protocol violation (req dropped before ready): the access still completes and the ready pulse is still issued. No abort.
- Reset asserted mid-access: return to IDLE immediately with all outputs at reset values. The in-flight access is abandoned and no ready pulse is issued. A memory write already strobed may have landed.

## Timing
- Request sampled high at the edge ending cycle T (in IDLE):
  - `mem_en` is high in cycle T+1.
  - `mem_rdata` is sampled in cycle T+1+LATENCY.
  - ready is high in cycle T+2+LATENCY.
- Request-to-ready latency is LATENCY+2 cycles. Back-to-back occupancy is LATENCY+3 cycles per access, because of the IDLE arbitration cycle.
- With simultaneous requests, the loser sees its `mem_en` LATENCY+3 cycles after the winner's.
- At most one ready pulse per cycle. `i_ready` and `d_ready` are never high together.
- `mem_en` is never high in two consecutive cycles.

## Test plan
- **Single fetch**, LATENCY=2, `i_req`/`i_addr`=0x80 rise and are sampled at cycle 0; memory returns 0x1000FFFF -> `mem_en`=1, `mem_we`=0, `mem_addr`=0x80 in cycle 1; `i_ready`=1, `i_rdata`=0x1000FFFF in cycle 4 only.
- **Data write**, `d_we`=1, `d_addr`=0x80, `d_wdata`=0x0000DEAD -> `mem_en`=`mem_we`=1 with those values in cycle 1; `d_ready` in cycle 4; `d_rdata` unchanged.
- **Simultaneous** `i_req` and `d_req` at cycle 0 -> data granted (`gnt_d`=1), `d_ready` in cycle 4; fetch `mem_en` in cycle 6, `i_ready` in cycle 9.
- **Starvation guard**, MAX_DSTREAK=4, `d_req` and `i_req` held continuously -> exactly 4 data grants, then 1 fetch grant, then data again. The streak counter is 0 after the fetch grant.
- **Reset mid-access**: `reset` driven low during WAIT -> all outputs are 0 in the same cycle and no ready pulse occurs. After release with `d_req` held, a fresh access gives `mem_en` one cycle after the first IDLE sample.
- **Idle**: no requests for 100 cycles -> `mem_en`, `i_ready`, `d_ready` stay 0. With LATENCY=1, a single read gives ready in cycle 3.
